ncl_th_gate_bank: RTL and testbench



---
 rtl/ncl_pkg.sv | 6 +
 rtl/ncl_th22_cell.sv | 23 ++
 rtl/ncl_th_gate_bank.sv | 47 ++++
 tb/tb_ncl_th_gate_bank.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Shared NCL rail encodings and widths for the threshold-gate primitive layer.
package ncl_pkg;
   localparam logic        NULL_V    = 1'b0;
   localparam logic        DATA_V    = 1'b1;
   localparam int unsigned NCL_RAILS = 4;
endpackage

// File: rtl/ncl_th22_cell.sv
// Single clocked 2-of-2 C-element with hysteresis and a synchronous NULL clear.
module ncl_th22_cell
   import ncl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic a,
   input  logic b,
   output logic z
);

   // clr outranks the data inputs so an init pulse always yields NULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         z <= NULL_V;
      else if (clr)
         z <= NULL_V;
      else
         z <= (a & b) | (z & (a | b));
   end

endmodule

// File: rtl/ncl_th_gate_bank.sv
// Bank of LANES clocked TH14, TH22 and TH22N threshold gates; one gate delay is one clock.
module ncl_th_gate_bank
   import ncl_pkg::*;
#(
   parameter int unsigned LANES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       init,
   input  logic [NCL_RAILS*LANES-1:0] th14_a,
   output logic [LANES-1:0]           th14_z,
   input  logic [LANES-1:0]           th22_a,
   input  logic [LANES-1:0]           th22_b,
   output logic [LANES-1:0]           th22_z,
   input  logic [LANES-1:0]           th22n_a,
   input  logic [LANES-1:0]           th22n_b,
   output logic [LANES-1:0]           th22n_z
);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            th14_z[i] <= NULL_V;
         else
            th14_z[i] <= |th14_a[NCL_RAILS*i +: NCL_RAILS];
      end

      ncl_th22_cell u_th22 (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (1'b0),
         .a     (th22_a[i]),
         .b     (th22_b[i]),
         .z     (th22_z[i])
      );

      ncl_th22_cell u_th22n (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (init),
         .a     (th22n_a[i]),
         .b     (th22n_b[i]),
         .z     (th22n_z[i])
      );
   end

endmodule

// File: tb/tb_ncl_th_gate_bank.sv
// Directed and reference-model checks for the NCL threshold-gate bank at LANES=4.
module tb_ncl_th_gate_bank;
   localparam int unsigned L = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           init;
   logic [4*L-1:0] th14_a;
   logic [L-1:0]   th14_z;
   logic [L-1:0]   th22_a, th22_b, th22_z;
   logic [L-1:0]   th22n_a, th22n_b, th22n_z;

   int unsigned total = 0;
   int unsigned bad   = 0;

   ncl_th_gate_bank #(.LANES(L)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .init    (init),
      .th14_a  (th14_a),
      .th14_z  (th14_z),
      .th22_a  (th22_a),
      .th22_b  (th22_b),
      .th22_z  (th22_z),
      .th22n_a (th22n_a),
      .th22n_b (th22n_b),
      .th22n_z (th22n_z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference model state for the random lane-independence run
   logic [L-1:0] m14, m22, m22n;

   initial begin
      // reset held with random inputs
      rst_n = 1'b0;
      init  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         th14_a  = 16'($urandom);
         th22_a  = 4'($urandom);
         th22_b  = 4'($urandom);
         th22n_a = 4'($urandom);
         th22n_b = 4'($urandom);
         init    = 1'($urandom);
         step();
         chk("rst_th14", 64'(th14_z), 64'h0);
         chk("rst_th22", 64'(th22_z), 64'h0);
         chk("rst_th22n", 64'(th22n_z), 64'h0);
      end
      th14_a = '0; th22_a = '0; th22_b = '0; th22n_a = '0; th22n_b = '0; init = 1'b0;
      rst_n = 1'b1;
      step();
      chk("post_rst", 64'({th14_z, th22_z, th22n_z}), 64'h0);

      // TH14 lane 0 directed
      th14_a = 16'h0000; step(); chk("th14_0000", 64'(th14_z), 64'h0);
      th14_a = 16'h0004; #1;
      chk("th14_latency", 64'(th14_z), 64'h0);
      step(); chk("th14_0100", 64'(th14_z), 64'h1);
      th14_a = 16'h000f; step(); chk("th14_1111", 64'(th14_z), 64'h1);
      th14_a = 16'h0000; #1;
      chk("th14_hold1", 64'(th14_z), 64'h1);
      step(); chk("th14_back0", 64'(th14_z), 64'h0);

      // TH14 all 16 codes on every lane
      for (int ln = 0; ln < 4; ln++) begin
         for (int c = 0; c < 16; c++) begin
            th14_a = 16'(c) << (4 * ln);
            step();
            chk("th14_code", 64'(th14_z), (c != 0) ? (64'h1 << ln) : 64'h0);
         end
      end
      th14_a = '0;

      // TH22 hysteresis sequence, all lanes driven alike
      begin
         logic [1:0] ab [6];
         logic       ez [6];
         ab = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
         ez = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
         for (int k = 0; k < 6; k++) begin
            th22_a = {4{ab[k][1]}};
            th22_b = {4{ab[k][0]}};
            step();
            chk("th22_seq", 64'(th22_z), 64'({4{ez[k]}}));
         end
      end

      // TH22N init pulse vs TH22 with identical inputs
      th22_a = 4'hf; th22_b = 4'hf; th22n_a = 4'hf; th22n_b = 4'hf;
      step();
      chk("th22n_set", 64'(th22n_z), 64'hf);
      chk("th22_set", 64'(th22_z), 64'hf);
      init = 1'b1; step();
      chk("th22n_init", 64'(th22n_z), 64'h0);
      chk("th22_noinit", 64'(th22_z), 64'hf);
      init = 1'b0; step();
      chk("th22n_rel", 64'(th22n_z), 64'hf);

      // asynchronous reset mid-cycle with init also high
      #3;
      init = 1'b1; rst_n = 1'b0; #1;
      chk("async_th22", 64'(th22_z), 64'h0);
      chk("async_th22n", 64'(th22n_z), 64'h0);
      step();
      chk("rst_init", 64'({th22_z, th22n_z}), 64'h0);
      init = 1'b0; rst_n = 1'b1;
      th22_a = 4'hf; th22_b = 4'h0; th22n_a = 4'h0; th22n_b = 4'hf;
      step();
      chk("rel_hold22", 64'(th22_z), 64'h0);
      chk("rel_hold22n", 64'(th22n_z), 64'h0);
      th22_b = 4'hf; th22n_a = 4'hf;
      step();
      chk("rel_both", 64'({th22_z, th22n_z}), 64'hff);

      // 4-rail pipeline stage: th14 lane 0 is completion on th22n_z
      th22n_a = '0; th22n_b = '0; th14_a = '0;
      step(); step();
      chk("pipe_null", 64'({th22n_z, th14_z}), 64'h00);
      th22n_a = 4'b0010; th22n_b = 4'hf;
      step();
      chk("pipe_data", 64'(th22n_z), 64'h2);
      chk("pipe_comp0", 64'(th14_z[0]), 64'h0);
      th14_a = {12'h0, th22n_z};
      step();
      chk("pipe_comp1", 64'(th14_z[0]), 64'h1);
      th22n_a = 4'h0; th22n_b = 4'h0; th14_a = {12'h0, th22n_z};
      step();
      chk("pipe_nullz", 64'(th22n_z), 64'h0);
      th14_a = {12'h0, th22n_z};
      step();
      chk("pipe_comp_null", 64'(th14_z[0]), 64'h0);

      // random lane independence against a reference model
      rst_n = 1'b0; #2; rst_n = 1'b1;
      m14 = '0; m22 = '0; m22n = '0;
      for (int n = 0; n < 1000; n++) begin
         th14_a  = 16'($urandom);
         th22_a  = 4'($urandom);
         th22_b  = 4'($urandom);
         th22n_a = 4'($urandom);
         th22n_b = 4'($urandom);
         init    = ($urandom_range(0, 9) == 0);
         for (int ln = 0; ln < 4; ln++) begin
            m14[ln] = (th14_a[4*ln +: 4] != 4'h0);
            if (th22_a[ln] == th22_b[ln]) m22[ln] = th22_a[ln];
            if (init) m22n[ln] = 1'b0;
            else if (th22n_a[ln] == th22n_b[ln]) m22n[ln] = th22n_a[ln];
         end
         step();
         chk("rnd_th14", 64'(th14_z), 64'(m14));
         chk("rnd_th22", 64'(th22_z), 64'(m22));
         chk("rnd_th22n", 64'(th22n_z), 64'(m22n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
